// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong geometry constants and paddle FSM state type
package pong_pkg;

    localparam int SCREEN_H = 480;
    localparam int SCREEN_W = 640;
    localparam int PADDLE_H = 120;
    localparam int PADDLE_W = 10;
    localparam int Y_W      = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_DN = 2'd1,
        MOVE_UP = 2'd2
    } paddle_st_t;

endpackage

// File: rtl/paddle_ctrl_if.sv
// rtl/paddle_ctrl_if.sv - paddle controller button/ball inputs and position outputs
interface paddle_ctrl_if #(
    parameter int NUM_PADDLES = 2,
    parameter int Y_W         = pong_pkg::Y_W
);

    logic [NUM_PADDLES-1:0]     btn_dn_n;
    logic [NUM_PADDLES-1:0]     btn_up_n;
    logic [NUM_PADDLES-1:0]     auto_en;
    logic [Y_W-1:0]             ball_y;
    logic [NUM_PADDLES*Y_W-1:0] paddle_y;
    logic                       tick;

    modport master (
        output btn_dn_n,
        output btn_up_n,
        output auto_en,
        output ball_y,
        input  paddle_y,
        input  tick
    );

    modport slave (
        input  btn_dn_n,
        input  btn_up_n,
        input  auto_en,
        input  ball_y,
        output paddle_y,
        output tick
    );

endinterface

// File: rtl/paddle_channel.sv
// rtl/paddle_channel.sv - one paddle: button sync, move FSM, acceleration, clamp, auto-track
module paddle_channel
    import pong_pkg::*;
#(
    parameter int Y_W         = 10,
    parameter int Y_MAX       = 360,
    parameter int HALF_H      = 60,
    parameter int Y_INIT      = 180,
    parameter int ACCEL_TICKS = 32,
    parameter int MAX_STEP    = 4,
    parameter int AUTO_STEP   = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick_i,
    input  logic           btn_dn_n_i,
    input  logic           btn_up_n_i,
    input  logic           auto_en_i,
    input  logic [Y_W-1:0] ball_y_i,
    output logic [Y_W-1:0] paddle_y_o
);

    localparam int W1  = Y_W + 1;
    localparam int S_W = (MAX_STEP > 1) ? $clog2(MAX_STEP + 1) : 1;
    localparam int H_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [Y_W-1:0] Y_MAX_Y   = Y_W'(Y_MAX);
    localparam logic [W1-1:0]  Y_MAX_X   = W1'(Y_MAX);
    localparam logic [Y_W-1:0] HALF_Y    = Y_W'(HALF_H);
    localparam logic [Y_W-1:0] AUTO_Y    = Y_W'(AUTO_STEP);
    localparam logic [S_W-1:0] MAX_S     = S_W'(MAX_STEP);
    localparam logic [H_W:0]   ACCEL_H   = (H_W + 1)'(ACCEL_TICKS);
    localparam logic [S_W-1:0] STEP_ONE  = S_W'(1);

    logic [1:0]     dn_sync_q, up_sync_q;
    logic           auto_prev_q;
    paddle_st_t     state_q, state_d;
    logic [S_W-1:0] step_q, step_d;
    logic [H_W-1:0] hold_q, hold_d;
    logic [Y_W-1:0] y_q, y_d;

    logic dn_req, up_req, auto_edge;

    assign dn_req    = ~dn_sync_q[1];
    assign up_req    = ~up_sync_q[1];
    assign auto_edge = auto_en_i ^ auto_prev_q;

    // two-flop synchronisers for the asynchronous buttons, idle high; auto_en history for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dn_sync_q   <= 2'b11;
            up_sync_q   <= 2'b11;
            auto_prev_q <= 1'b0;
        end else begin
            dn_sync_q   <= {dn_sync_q[0], btn_dn_n_i};
            up_sync_q   <= {up_sync_q[0], btn_up_n_i};
            auto_prev_q <= auto_en_i;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: auto mode or a mode change parks the FSM; otherwise buttons decide on tick
    always_comb begin
        state_d = state_q;
        if (auto_edge || auto_en_i) begin
            state_d = IDLE;
        end else if (tick_i) begin
            if (dn_req && !up_req) begin
                state_d = MOVE_DN;
            end else if (up_req && !dn_req) begin
                state_d = MOVE_UP;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // position, step and hold-counter updates for manual and auto-track movement
    always_comb begin
        logic [S_W-1:0] step_eff;
        logic [H_W-1:0] hold_eff;
        logic [H_W:0]   hold_inc;
        logic [W1-1:0]  dn_sum;
        logic [Y_W-1:0] target;
        logic [Y_W-1:0] diff;

        step_d   = step_q;
        hold_d   = hold_q;
        y_d      = y_q;
        step_eff = step_q;
        hold_eff = hold_q;
        hold_inc = '0;
        dn_sum   = '0;
        target   = '0;
        diff     = '0;

        if (auto_edge) begin
            step_d = STEP_ONE;
            hold_d = '0;
        end

        if (auto_en_i) begin
            if (tick_i) begin
                // ball centre aligned to paddle centre, kept on screen
                target = (ball_y_i < HALF_Y) ? '0 : ball_y_i - HALF_Y;
                if (target > Y_MAX_Y) begin
                    target = Y_MAX_Y;
                end
                if (target >= y_q) begin
                    diff = target - y_q;
                    y_d  = (diff <= AUTO_Y) ? target : y_q + AUTO_Y;
                end else begin
                    diff = y_q - target;
                    y_d  = (diff <= AUTO_Y) ? target : y_q - AUTO_Y;
                end
            end
        end else if (!auto_edge && tick_i) begin
            if (state_d == IDLE) begin
                step_d = STEP_ONE;
                hold_d = '0;
            end else begin
                if (state_d != state_q) begin
                    step_eff = STEP_ONE;
                    hold_eff = '0;
                end
                if (state_d == MOVE_DN) begin
                    dn_sum = {1'b0, y_q} + W1'(step_eff);
                    y_d    = (dn_sum > Y_MAX_X) ? Y_MAX_Y : dn_sum[Y_W-1:0];
                end else begin
                    y_d = (y_q >= Y_W'(step_eff)) ? y_q - Y_W'(step_eff) : '0;
                end
                // clamped moves still count toward acceleration
                hold_inc = {1'b0, hold_eff} + 1'b1;
                step_d   = step_eff;
                if (hold_inc >= ACCEL_H) begin
                    if (step_eff < MAX_S) begin
                        step_d = step_eff + 1'b1;
                        hold_d = '0;
                    end else begin
                        hold_d = H_W'(ACCEL_TICKS);
                    end
                end else begin
                    hold_d = hold_inc[H_W-1:0];
                end
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q <= STEP_ONE;
            hold_q <= '0;
            y_q    <= Y_W'(Y_INIT);
        end else begin
            step_q <= step_d;
            hold_q <= hold_d;
            y_q    <= y_d;
        end
    end

    assign paddle_y_o = y_q;

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - movement-tick prescaler and per-channel paddle instances
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PADDLES = 2,
    parameter int Y_W         = pong_pkg::Y_W,
    parameter int SCREEN_H    = pong_pkg::SCREEN_H,
    parameter int PADDLE_H    = pong_pkg::PADDLE_H,
    parameter int Y_INIT      = 180,
    parameter int TICK_DIV    = 125000,
    parameter int ACCEL_TICKS = 32,
    parameter int MAX_STEP    = 4,
    parameter int AUTO_STEP   = 2
) (
    input  logic         clk,
    input  logic         reset,
    paddle_ctrl_if.slave bus
);

    localparam int Y_MAX = SCREEN_H - PADDLE_H;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       tick_w;
    logic [NUM_PADDLES*Y_W-1:0] y_pack;

    assign tick_w = (cnt_q == CNT_LAST);

    // prescaler wraps after the tick cycle
    always_comb begin
        cnt_d = tick_w ? '0 : cnt_q + 1'b1;
    end

    // prescaler register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_PADDLES; k++) begin : g_ch
        paddle_channel #(
            .Y_W        (Y_W),
            .Y_MAX      (Y_MAX),
            .HALF_H     (PADDLE_H / 2),
            .Y_INIT     (Y_INIT),
            .ACCEL_TICKS(ACCEL_TICKS),
            .MAX_STEP   (MAX_STEP),
            .AUTO_STEP  (AUTO_STEP)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick_i    (tick_w),
            .btn_dn_n_i(bus.btn_dn_n[k]),
            .btn_up_n_i(bus.btn_up_n[k]),
            .auto_en_i (bus.auto_en[k]),
            .ball_y_i  (bus.ball_y),
            .paddle_y_o(y_pack[k*Y_W +: Y_W])
        );
    end

    assign bus.paddle_y = y_pack;
    assign bus.tick     = tick_w;

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Parametrised paddle position controller for the Pong datapath. Drives NUM_PADDLES independent paddles from active-low up/down buttons, or from an auto-track mode that follows the ball. Adds hold-to-accelerate, screen clamping and a clock-enable movement tick in the single `clk` domain, with no derived clock. Outputs feed the renderer and the collision logic.

## Interface
Parameters:
- NUM_PADDLES, 2, number of independent paddle channels
- Y_W, 10, position width in bits
- SCREEN_H, 480, visible lines
- PADDLE_H, 120, paddle height in lines
- Y_INIT, 180, reset position (top edge)
- TICK_DIV, 125000, clk cycles per movement tick
- ACCEL_TICKS, 32, consecutive move ticks before step increments
- MAX_STEP, 4, maximum lines per tick (manual)
- AUTO_STEP, 2, lines per tick in auto mode

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; sole reset
- btn_dn_n  in  NUM_PADDLES  active-low, asynchronous; moves paddle down (y increases)
- btn_up_n  in  NUM_PADDLES  active-low, asynchronous; moves paddle up (y decreases)
- auto_en  in  NUM_PADDLES  per-channel auto-track enable, synchronous to clk
- ball_y  in  Y_W  ball top-edge line, synchronous to clk
- paddle_y  out  NUM_PADDLES*Y_W  positions; channel k occupies bits [k*Y_W +: Y_W]
- tick  out  1  one-cycle movement strobe

## Operation
- Y_MAX = SCREEN_H - PADDLE_H (360 at defaults). paddle_y always lies in [0, Y_MAX].
- Buttons pass through 2-FF synchronisers. Sync registers reset to 1 (released).
- Prescaler counts 0..TICK_DIV-1 and wraps. `tick` = 1 when count == TICK_DIV-1.
- Per channel, manual mode (auto_en=0), FSM {IDLE, MOVE_DN, MOVE_UP}, evaluated only on tick:
  - dn only -> MOVE_DN; up only -> MOVE_UP; both or neither -> IDLE, no motion.
  - Entering a state from a different state loads step=1 and hold=0 before the move.
  - Move by step: down y' = min(y+step, Y_MAX); up y' = (y >= step) ? y-step : 0. Compute in Y_W+1 bits to avoid wrap.
  - After a move, hold increments. If hold reaches ACCEL_TICKS and step < MAX_STEP, then step++ and hold=0. At MAX_STEP, hold saturates.
  - A clamped move (position pinned at a limit) still counts toward acceleration.
- Auto mode (auto_en=1): buttons ignored. target = ball_y - PADDLE_H/2, clamped to [0, Y_MAX] (ball_y < PADDLE_H/2 gives 0).
  - On tick: if |target-y| <= AUTO_STEP, y' = target; otherwise y moves AUTO_STEP toward target.
- Any auto_en edge forces FSM=IDLE, step=1, hold=0 on the next clk. Position is retained.
- Channels are fully independent and share only the prescaler.

## Timing
- Reset (async assert, sync-safe deassert by system): paddle_y = Y_INIT on all channels; prescaler=0; tick=0; FSM IDLE; step=1; hold=0.
- Button-to-effect: 2 clk synchroniser latency, then the first tick samples the button. paddle_y updates on the clk edge at which tick=1 and is visible the next cycle.
- ball_y and auto_en are sampled directly at tick with no added latency.
- Reset mid-move: outputs return to reset values immediately. The first tick after release occurs TICK_DIV cycles later.
- Direction reversal within one tick period: the new direction is applied at the next tick with step=1.

## Structure
- Shared package `pong_pkg`: SCREEN_H, SCREEN_W=640, PADDLE_H, PADDLE_W=10, Y_W, and typedef `paddle_st_t` {IDLE, MOVE_DN, MOVE_UP}.
- Sub-module `paddle_channel`: synchroniser, FSM, step/hold, clamp and auto logic for one channel. Instantiated in a generate loop.
- Top level holds the prescaler and the output packing.

## Test plan
(TICK_DIV=4, ACCEL_TICKS=4, MAX_STEP=3 unless noted)
- Reset, then btn_dn_n[0]=0 held for 10 ticks -> paddle_y[0] = 184 after tick 4, 192 after tick 8, 198 after tick 10; paddle_y[1] stays 180.
- Paddle 0 at 358 with step=3, down held -> 360 and stays at 360; acceleration continues with no wrap. Paddle at 1 with step=2, up held -> 0 and stays at 0.
- Both buttons low for 3 ticks -> no motion. Then dn only -> step restarts at 1 (+1 per tick). Reversal dn->up mid-ramp -> first up move is 1.
- auto_en[1]=1, ball_y=400, start 180 -> target 340, +2 per tick, reaches 340 after 80 ticks, then holds. ball_y=30 -> moves toward 0 and ends exactly at 0.
- Button pulse shorter than TICK_DIV falling between ticks -> no motion. Pulse spanning a tick (after 2-cycle sync) -> exactly one move.
- reset asserted mid-ramp at 250 -> paddle_y=180 and tick=0 in the same cycle. After release, the first tick occurs 4 cycles later with step=1.
